// File: rtl/spi_master.sv
// SPI master, one byte per frame, CPOL/CPHA selectable, half-period = clk_div_val+1 sys_clk cycles.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting (MSB-first otherwise).
`timescale 1ns/1ps
module spi_master #(
    parameter logic CPOL = 1'b1,
    parameter logic CPHA = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic        cs,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    input  logic [15:0] clk_div_val,
    input  logic        wr_req,
    input  logic [7:0]  data_tx,
    output logic        wr_ack,
    output logic [7:0]  data_rx,
    output logic        busy
);

    typedef enum logic [2:0] {
        S0_IDLE      = 3'd0,
        S1_HALF_WAIT = 3'd1,
        S2_SCLK_EDGE = 3'd2,
        S3_LAST_HALF = 3'd3,
        S4_ACK       = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] div_q;
    logic [15:0] half_cnt;
    logic [4:0]  edge_cnt;
    logic [4:0]  edge_nxt;
    logic [7:0]  tx_sr, rx_sr;
    logic [7:0]  tx_shifted, rx_shifted;
    logic        sclk_q;
    logic        start, edge_evt, load_rx;
    logic        half_end, smp_edge, sft_edge;

    // Compare-before-increment: half_cnt never exceeds div_q, so 16 bits cover H=65536.
    assign half_end = (half_cnt == div_q);
    assign edge_nxt = edge_cnt + 5'd1;
    assign smp_edge = CPHA ? ~edge_nxt[0] : edge_nxt[0];
    assign sft_edge = CPHA ? (edge_nxt[0] && (edge_nxt >= 5'd3))
                           : (!edge_nxt[0] && (edge_nxt <= 5'd14));

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi       = tx_sr[0];
    assign tx_shifted = {1'b0, tx_sr[7:1]};
    assign rx_shifted = {miso, rx_sr[7:1]};
`else
    assign mosi       = tx_sr[7];
    assign tx_shifted = {tx_sr[6:0], 1'b0};
    assign rx_shifted = {rx_sr[6:0], miso};
`endif

    assign busy   = (state == S1_HALF_WAIT) || (state == S2_SCLK_EDGE) || (state == S3_LAST_HALF);
    assign cs     = ~busy;
    assign wr_ack = (state == S4_ACK);
    assign sclk   = sclk_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= S0_IDLE;
        else         state <= state_nxt;
    end

    // sclk toggles on the transition into S2, so the S2 cycle is the first cycle
    // of the next half-period; with H=1 S2 chains into itself.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        edge_evt  = 1'b0;
        case (state)
            S0_IDLE: begin
                if (wr_req) begin
                    start     = 1'b1;
                    state_nxt = S1_HALF_WAIT;
                end
            end
            S1_HALF_WAIT: begin
                if (half_end) begin
                    edge_evt  = 1'b1;
                    state_nxt = S2_SCLK_EDGE;
                end
            end
            S2_SCLK_EDGE: begin
                if (half_end) begin
                    if (edge_cnt == 5'd16) begin
                        state_nxt = S4_ACK;
                    end else begin
                        edge_evt  = 1'b1;
                        state_nxt = S2_SCLK_EDGE;
                    end
                end else begin
                    state_nxt = (edge_cnt == 5'd16) ? S3_LAST_HALF : S1_HALF_WAIT;
                end
            end
            S3_LAST_HALF: begin
                if (half_end) state_nxt = S4_ACK;
            end
            S4_ACK:  state_nxt = S0_IDLE;
            default: state_nxt = S0_IDLE;
        endcase
        load_rx = (state_nxt == S4_ACK) && (state != S4_ACK);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q    <= '0;
            half_cnt <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            data_rx  <= '0;
            sclk_q   <= CPOL;
        end else begin
            if (start) begin
                div_q    <= clk_div_val;
                tx_sr    <= data_tx;
                rx_sr    <= '0;
                half_cnt <= '0;
                edge_cnt <= '0;
            end else if (busy) begin
                half_cnt <= half_end ? '0 : half_cnt + 16'd1;
            end
            if (edge_evt) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_nxt;
                if (smp_edge) rx_sr <= rx_shifted;
                if (sft_edge) tx_sr <= tx_shifted;
            end
            if (load_rx) data_rx <= rx_sr;
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CPOL, default 1'b1, is the sclk idle level.
REQ-002 Parameter CPHA, default 1'b1: 0 samples on the first edge of each bit, 1 samples on the second edge.
REQ-003 sys_clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 sys_rst  input  1  reset, synchronous and active-high.
REQ-005 cs  output  1  chip select, active-low.
REQ-006 sclk  output  1  serial clock.
REQ-007 mosi  output  1  master-out serial data.
REQ-008 miso  input  1  master-in serial data, synchronous to sys_clk (external synchroniser).
REQ-009 clk_div_val  input  16  half-period select; half-period H = clk_div_val+1 sys_clk cycles.
REQ-010 wr_req  input  1  transfer request, sampled only when idle.
REQ-011 data_tx  input  8  byte to send, captured with wr_req.
REQ-012 wr_ack  output  1  one-cycle pulse marking transfer complete.
REQ-013 data_rx  output  8  last received byte.
REQ-014 busy  output  1  high while a transfer is in progress.

Function
REQ-015 States: S0_IDLE, S1_HALF_WAIT, S2_SCLK_EDGE, S3_LAST_HALF, S4_ACK; encoding is 3 bits.
REQ-016 In S0_IDLE with wr_req=1 at cycle N: latch data_tx and clk_div_val; cs=0, busy=1 from N+1; enter S1_HALF_WAIT.
REQ-017 S1_HALF_WAIT counts H cycles including the entry cycle, then goes to S2_SCLK_EDGE for one cycle, which toggles sclk and increments a 5-bit edge counter.
REQ-018 After edges 1..15, S2 returns to S1; after edge 16, S2 goes to S3_LAST_HALF.
REQ-019 Edge k (k=1..16) appears on sclk exactly k*H cycles after cs falls.
REQ-020 S3_LAST_HALF waits H cycles, then enters S4_ACK.
REQ-021 In S4_ACK: cs=1, wr_ack=1 for one cycle, data_rx is updated, busy=0; the next state is S0_IDLE; cs is low exactly 17*H cycles.
REQ-022 CPHA=0:
  - mosi carries the first bit from the cs fall.
  - miso is sampled on odd edges.
  - mosi shifts on even edges 2..14; edge 16 does not shift.
REQ-023 CPHA=1:
  - mosi shifts to the next bit on odd edges 3..15.
  - The first bit is driven from the cs fall.
  - miso is sampled on even edges.
REQ-024 Bit order is MSB first (default); data_rx equals the 8 sampled bits in arrival order.
REQ-025 sclk equals CPOL whenever cs=1 and after edge 16.
REQ-026 wr_req while busy=1 is ignored with no queueing; data_tx and clk_div_val changes mid-transfer have no effect.
REQ-027 The earliest next accept is the cycle after wr_ack (S0_IDLE).
REQ-028 clk_div_val=0 gives H=1 (sclk = sys_clk/2); clk_div_val=16'hFFFF gives H=65536 with no counter overflow (17-bit counter or compare-before-increment).

Reset
REQ-029 With sys_rst=1 at any time, the next state is:
  - state S0_IDLE, cs=1, sclk=CPOL, mosi=0
  - wr_ack=0, busy=0, data_rx=8'h00
  - counters and shift registers zero
REQ-030 Reset mid-transfer aborts with no wr_ack; wr_req in the reset cycle is ignored.

Configuration
REQ-031 Macro SPI_MASTER_LSB_FIRST_EN:
  - Defined: transmit data_tx[0] first and place the first received bit in data_rx[0].
  - Undefined: MSB-first per REQ-024.
  - Timing is identical either way.

Verification
REQ-032 CPOL=1, CPHA=1, clk_div_val=1, data_tx=8'hA5, miso looped to mosi -> cs low 34 cycles, 16 sclk edges 2 cycles apart, wr_ack once, data_rx=8'hA5.
REQ-033 CPOL=0, CPHA=0, clk_div_val=0, data_tx=8'h3C, slave model returns 8'hC3 -> mosi bits 0,0,1,1,1,1,0,0 valid at rising edges, data_rx=8'hC3, cs low 17 cycles.
REQ-034 wr_req held high continuously for 3 transfers with 8'h01, 8'h80, 8'hFF -> exactly 3 wr_ack pulses, one idle cs-high cycle between frames, data_tx pulses during busy ignored.
REQ-035 sys_rst asserted at edge 7 of a transfer -> next cycle cs=1, sclk=CPOL, busy=0, no wr_ack; a following request with data_tx=8'h5A completes normally.
REQ-036 SPI_MASTER_LSB_FIRST_EN defined, data_tx=8'h01, loopback -> first mosi bit=1, data_rx=8'h01; with 8'h80 the first bit=0 and data_rx=8'h80.
REQ-037 clk_div_val=16'hFFFF, one transfer -> edge spacing 65536 cycles, cs low 1114112 cycles, no premature edge.
